piso_serializer: RTL and testbench

- Parallel-in serial-out serializer that generates the serial bit stream feeding the 4-stage serial shift register (its i_d input).
- Accepts a WIDTH-bit word over a valid/ready handshake, then shifts it out one bit per clock with a bit-valid strobe.
- Words can be accepted back-to-back, so the serial stream has no gap between consecutive words.

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_shreg.sv | 40 ++++
 rtl/piso_serializer.sv | 163 ++++++++++++++++
 tb/tb_piso_serializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out serializer.
// State encoding and the default word width live here so the top and any
// checkers bound to the debug state output agree on the encoding.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_e;

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register for the serializer.
// A parallel load has priority over a shift. Shifting moves towards the
// output end selected by MSB_FIRST and fills the vacated bit with zero.
module piso_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
            assign bit_o        = sreg_q[WIDTH-1];
        end else begin : g_lsb_first
            assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
            assign bit_o        = sreg_q[0];
        end
    endgenerate

    // Shift register: clear on reset, parallel load on accept, shift otherwise when enabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg_q <= '0;
        end else if (load_i) begin
            sreg_q <= data_i;
        end else if (shift_i) begin
            sreg_q <= sreg_shifted;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer.
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it one bit
// per clock on o_sd with o_sd_en marking every payload (and parity) bit.
// Handshake: a word transfers at a rising edge where i_valid && o_ready;
// o_ready depends only on state, bit counter and i_rst, never on i_valid.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit after
// the last data bit, extending the frame to WIDTH+1 cycles.
// o_dbg_state exposes the FSM state for checkers.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_sd,
    output logic             o_sd_en,
    output logic             o_busy,
    output logic [1:0]       o_dbg_state
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    piso_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q;
    logic          load;
    logic          shift;
    logic          accept;
    logic          last_bit;
    logic          shreg_bit;
`ifdef PISO_PARITY_EN
    logic          parity_q;
`endif

    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign accept   = i_valid && o_ready;

    // Ready decode: free in IDLE and on the final bit of a frame, never during reset.
    always_comb begin
        o_ready = 1'b0;
        if (!i_rst) begin
            case (state_q)
                ST_IDLE:   o_ready = 1'b1;
`ifdef PISO_PARITY_EN
                ST_SHIFT:  o_ready = 1'b0;
                ST_PARITY: o_ready = 1'b1;
`else
                ST_SHIFT:  o_ready = last_bit;
`endif
                default:   o_ready = 1'b0;
            endcase
        end
    end

    // Next-state, counter and shift-register control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                    shift = 1'b1;
                end else begin
`ifdef PISO_PARITY_EN
                    shift   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_PARITY;
`else
                    cnt_d = '0;
                    if (accept) begin
                        // Reload on the last bit keeps the stream gap-free.
                        load = 1'b1;
                    end else begin
                        shift   = 1'b1;
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                cnt_d = '0;
                if (accept) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, bit counter and registered activity flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            active_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= (state_d != ST_IDLE);
`ifdef PISO_PARITY_EN
            if (load) begin
                parity_q <= ^i_data;
            end
`endif
        end
    end

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (i_data),
        .bit_o   (shreg_bit)
    );

    // Serial data select: only registered sources, so o_sd moves on the rising edge or reset.
    always_comb begin
        o_sd = 1'b0;
        case (state_q)
            ST_SHIFT:  o_sd = shreg_bit;
`ifdef PISO_PARITY_EN
            ST_PARITY: o_sd = parity_q;
`endif
            default:   o_sd = 1'b0;
        endcase
    end

    assign o_sd_en     = active_q;
    assign o_busy      = active_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: one MSB-first and one LSB-first instance
// (WIDTH = 8) sharing clock and reset, with a bit scoreboard per instance
// and a 4-stage falling-edge downstream register on the MSB-first stream.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = W + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = W;
    localparam bit PAR   = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         vm, vl;
    logic [W-1:0] dm, dl;
    logic         rdy_m, sd_m, en_m, busy_m;
    logic         rdy_l, sd_l, en_l, busy_l;
    logic [1:0]   st_m, st_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(clk), .i_rst(rst), .i_valid(vm), .i_data(dm),
        .o_ready(rdy_m), .o_sd(sd_m), .o_sd_en(en_m), .o_busy(busy_m),
        .o_dbg_state(st_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(clk), .i_rst(rst), .i_valid(vl), .i_data(dl),
        .o_ready(rdy_l), .o_sd(sd_l), .o_sd_en(en_l), .o_busy(busy_l),
        .o_dbg_state(st_l)
    );

    int checks = 0;
    int errors = 0;

    logic [0:0] exp_m[$];
    logic [0:0] exp_l[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    // Push a frame: s holds the data bits in send order, bit 7 first.
    task automatic push_stream(input bit lsb, input logic [7:0] s, input logic p);
        for (int i = 7; i >= 0; i--) begin
            if (lsb) exp_l.push_back(s[i]);
            else     exp_m.push_back(s[i]);
        end
        if (PAR) begin
            if (lsb) exp_l.push_back(p);
            else     exp_m.push_back(p);
        end
    endtask

    // ---------------- driver ----------------
    // Called 1 ns after a rising edge; returns 1 ns after the accepting edge.
    task automatic send(input bit lsb, input logic [7:0] d, input logic [7:0] s,
                        input logic p, output int waited);
        waited = 0;
        if (lsb) begin vl = 1'b1; dl = d; end
        else     begin vm = 1'b1; dm = d; end
        while (!(lsb ? rdy_l : rdy_m) && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_ready expected=ready lsb=%0d", lsb);
        end else begin
            push_stream(lsb, s, p);
        end
        @(posedge clk); #1;
        // Garbage after the accepting edge must not reach the stream.
        if (lsb) begin vl = 1'b0; dl = 8'($urandom_range(0, 255)); end
        else     begin vm = 1'b0; dm = 8'($urandom_range(0, 255)); end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy_m || busy_l) && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy expected=idle");
        end
        @(negedge clk); #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    int         run_m = 0;
    int         last_run_m = 0;
    logic [3:0] chain = '0;
    logic [3:0] exp_chain = '0;
    logic [3:0] chain_vld = '0;

    always @(negedge clk) begin
        logic [0:0] e;
        logic [0:0] el;
        e = 1'b0;
        if (!rst) begin
            if (en_m) begin
                if (exp_m.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_en_msb actual=1 expected=0 t=%0t", $time);
                end else begin
                    e = exp_m.pop_front();
                    checks++;
                    if (sd_m !== e) begin
                        errors++;
                        $display("FAIL sd_msb actual=%0b expected=%0b t=%0t", sd_m, e, $time);
                    end
                end
                run_m++;
            end else begin
                if (run_m != 0) last_run_m = run_m;
                run_m = 0;
            end
            if (en_l) begin
                if (exp_l.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_en_lsb actual=1 expected=0 t=%0t", $time);
                end else begin
                    el = exp_l.pop_front();
                    checks++;
                    if (sd_l !== el) begin
                        errors++;
                        $display("FAIL sd_lsb actual=%0b expected=%0b t=%0t", sd_l, el, $time);
                    end
                end
            end
        end else begin
            run_m = 0;
        end
        // Downstream 4-stage register sampling o_sd on the falling edge.
        if (chain_vld[3]) begin
            checks++;
            if (chain[3] !== exp_chain[3]) begin
                errors++;
                $display("FAIL chain_q actual=%0b expected=%0b t=%0t", chain[3], exp_chain[3], $time);
            end
        end
        chain     = {chain[2:0], sd_m};
        exp_chain = {exp_chain[2:0], e};
        chain_vld = {chain_vld[2:0], en_m && !rst};
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic [7:0] msb_s;
        logic [7:0] lsb_s;
        logic       par;
    } vec_t;

    vec_t tab[6];

    initial begin
        int w;
        logic [7:0] d;

        tab[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
        tab[1] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};
        tab[2] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
        tab[3] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
        tab[4] = '{8'hC8, 8'b11001000, 8'b00010011, 1'b1};
        tab[5] = '{8'hFF, 8'b11111111, 8'b11111111, 1'b0};

        rst = 1'b1; vm = 1'b0; vl = 1'b0; dm = '0; dl = '0;

        // Reset state
        #2;
        check("rst_sd_en", en_m, 0);
        check("rst_sd", sd_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_ready_msb", rdy_m, 0);
        check("rst_ready_lsb", rdy_l, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", rdy_m, 1);
        check("post_rst_state", st_m, 0);

        // Single word: ready low until the last bit of the frame
        send(1'b0, 8'hA5, 8'b10100101, 1'b0, w);
        for (int k = 0; k < FRAME; k++) begin
            check("single_ready", rdy_m, (k == FRAME - 1) ? 1 : 0);
            check("single_en", en_m, 1);
            check("single_busy", busy_m, 1);
            @(posedge clk); #1;
        end
        check("single_en_after", en_m, 0);
        check("single_ready_after", rdy_m, 1);
        wait_idle();
        check("single_run", last_run_m, FRAME);

        // Back-to-back with valid held across words
        send(1'b0, 8'hA5, 8'b10100101, 1'b0, w);
        send(1'b0, 8'h3C, 8'b00111100, 1'b0, w);
        wait_idle();
        check("b2b_run", last_run_m, 2 * FRAME);

        // Valid raised mid-frame is held off until the frame ends
        send(1'b0, 8'hA5, 8'b10100101, 1'b0, w);
        repeat (2) begin @(posedge clk); #1; end
        send(1'b0, 8'hFF, 8'b11111111, 1'b0, w);
        check("busy_ignore_wait", w, FRAME - 3);
        wait_idle();
        check("busy_ignore_run", last_run_m, 2 * FRAME);

        // Reset after three bits: outputs drop without a clock edge
        send(1'b0, 8'hA5, 8'b10100101, 1'b0, w);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk); #2;
        check("midrst_en_before", en_m, 1);
        rst = 1'b1;
        #1;
        check("midrst_en", en_m, 0);
        check("midrst_sd", sd_m, 0);
        check("midrst_ready", rdy_m, 0);
        exp_m.delete();
        exp_l.delete();
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy_after", busy_m, 0);
        check("midrst_ready_after", rdy_m, 1);
        for (int k = 0; k < 10; k++) begin
            check("midrst_no_residual", en_m, 0);
            @(posedge clk); #1;
        end

        // Table vectors, back-to-back on each instance
        foreach (tab[i]) send(1'b0, tab[i].data, tab[i].msb_s, tab[i].par, w);
        wait_idle();
        check("table_msb_run", last_run_m, 6 * FRAME);
        foreach (tab[i]) send(1'b1, tab[i].data, tab[i].lsb_s, tab[i].par, w);
        wait_idle();

        // Random words with bit order and parity modelled here
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom_range(0, 255));
            send(1'b0, d, d, ^d, w);
            d = 8'($urandom_range(0, 255));
            send(1'b1, d, rev8(d), ^d, w);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_idle();

        check("msb_queue_empty", exp_m.size(), 0);
        check("lsb_queue_empty", exp_l.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
